// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: bubble opcode, memory-stage FSM states and the
// opcode-class predicates used by both execute forwarding and memory hazards.
package cpu_pkg;

    localparam logic [6:0] NOP_OPCODE = 7'b0100000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } mem_state_t;

    // LDR/STR family: 11xxxxx or 1000xxx
    function automatic logic is_mem_op(input logic [6:0] op);
        return ((op & 7'h60) == 7'h60) || ((op & 7'h78) == 7'h40);
    endfunction

    // Load/store direction comes from the L bit (instr[20])
    function automatic logic is_load(input logic [6:0] op, input logic l_bit);
        return is_mem_op(op) && l_bit;
    endfunction

    // Rn read: (!op[6] & op[3:0]!=0) | op[6:5]==2'b11
    function automatic logic uses_rn(input logic [6:0] op);
        return (((op & 7'h40) == 7'h00) && ((op & 7'h0F) != 7'h00)) ||
               ((op & 7'h60) == 7'h60);
    endfunction

    // Rm read: (!op[6] & op[4]) | (op[6:5]==11 & op[3]) | (op[6:2]==10010 & op[0])
    function automatic logic uses_rm(input logic [6:0] op);
        return ((op & 7'h50) == 7'h10) ||
               ((op & 7'h68) == 7'h68) ||
               ((op & 7'h7D) == 7'h49);
    endfunction

    // Rs read (register-shifted register form): op[6:4]==3'b011
    function automatic logic uses_rs(input logic [6:0] op);
        return (op & 7'h70) == 7'h30;
    endfunction

endpackage

// File: rtl/mem_handshake_fsm.sv
// Data-memory req/ack sequencer with a bounded wait before declaring an error.
import cpu_pkg::*;

module mem_handshake_fsm #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        load_i,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output mem_state_t  state_o,
    output logic        req_o,
    output logic [31:0] rdata_o,
    output logic        timeout_o,
    output logic        error_o
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    mem_state_t  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        to_q, to_d;
    logic        err_q, err_d;

    // Next-state: ack wins over timeout; counting to MAX_WAIT unacked cycles aborts
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        to_d    = to_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_ACCESS;
                    cnt_d   = '0;
                    to_d    = 1'b0;
                end
            end
            ST_ACCESS: begin
                if (mem_ack_i) begin
                    state_d = ST_DONE;
                    if (load_i) rdata_d = mem_rdata_i;
                end else if (cnt_q == CW'(MAX_WAIT - 1)) begin
                    // this cycle's increment would reach MAX_WAIT
                    state_d = ST_DONE;
                    to_d    = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset abandons any access in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            to_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            to_q    <= to_d;
            err_q   <= err_d;
        end
    end

    assign state_o   = state_q;
    assign req_o     = (state_q == ST_ACCESS);
    assign rdata_o   = rdata_q;
    assign timeout_o = to_q;
    assign error_o   = err_q;

endmodule

// File: rtl/memory_unit.sv
// Memory pipeline stage: holds the instruction leaving execute, runs LDR/STR
// through the handshake FSM, publishes forwarding fields and raises stalls.
import cpu_pkg::*;

module memory_unit #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_in,
    input  logic [6:0]  opcode_in,
    input  logic [3:0]  rn_in,
    input  logic [3:0]  rd_in,
    input  logic [1:0]  sel_w_addr1_in,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic        branch_in,
    input  logic [6:0]  ex_opcode,
    input  logic [3:0]  ex_rn,
    input  logic [3:0]  ex_rm,
    input  logic [3:0]  ex_rs,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  rn_memory,
    output logic [3:0]  rd_memory,
    output logic [6:0]  opcode_memory,
    output logic [1:0]  sel_w_addr1_memory,
    output logic [31:0] wb_data,
    output logic        wb_valid,
    output logic        sel_stall,
    output logic        mem_error
);

    logic [6:0]  opcode_q;
    logic        ld_bit_q;
    logic [3:0]  rn_q, rd_q;
    logic [1:0]  sel_q;
    logic [31:0] alu_q, sd_q;
    logic        pending_q;   // memory op captured, FSM not yet started
    logic        alu_vld_q;   // non-memory op captured last edge

    mem_state_t  state;
    logic        req, timeout;
    logic [31:0] rdata;
    logic        held_mem, held_load, fsm_start, load_use;

    // Only the L bit of the instruction word matters in this stage
    logic instr_unused;
    assign instr_unused = ^{instr_in[31:21], instr_in[19:0]};

    assign held_mem  = is_mem_op(opcode_q);
    assign held_load = is_load(opcode_q, ld_bit_q);
    assign fsm_start = (state == ST_IDLE) && pending_q;

    // Forwarding can't cover a load result still in flight; wait until DONE
    assign load_use = held_load && (state == ST_IDLE || state == ST_ACCESS) &&
                      (ex_opcode != NOP_OPCODE) &&
                      ((uses_rn(ex_opcode) && ex_rn == rd_q) ||
                       (uses_rm(ex_opcode) && ex_rm == rd_q) ||
                       (uses_rs(ex_opcode) && ex_rs == rd_q));

    assign sel_stall = (state == ST_ACCESS) || fsm_start || load_use;

    // Pipeline register: flush inserts a bubble, stall holds (stall beats flush)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opcode_q  <= NOP_OPCODE;
            ld_bit_q  <= 1'b0;
            rn_q      <= '0;
            rd_q      <= '0;
            sel_q     <= '0;
            alu_q     <= '0;
            sd_q      <= '0;
            pending_q <= 1'b0;
            alu_vld_q <= 1'b0;
        end else if (!sel_stall) begin
            if (branch_in) begin
                opcode_q  <= NOP_OPCODE;
                pending_q <= 1'b0;
                alu_vld_q <= 1'b0;
            end else begin
                opcode_q  <= opcode_in;
                ld_bit_q  <= instr_in[20];
                rn_q      <= rn_in;
                rd_q      <= rd_in;
                sel_q     <= sel_w_addr1_in;
                alu_q     <= alu_result;
                sd_q      <= store_data;
                pending_q <= is_mem_op(opcode_in);
                alu_vld_q <= !is_mem_op(opcode_in) && (opcode_in != NOP_OPCODE);
            end
        end else begin
            alu_vld_q <= 1'b0;
            if (fsm_start) pending_q <= 1'b0;
        end
    end

    mem_handshake_fsm #(.MAX_WAIT(MAX_WAIT)) u_fsm (
        .clk         (clk),
        .rst         (rst),
        .start_i     (fsm_start),
        .load_i      (held_load),
        .mem_ack_i   (mem_ack),
        .mem_rdata_i (mem_rdata),
        .state_o     (state),
        .req_o       (req),
        .rdata_o     (rdata),
        .timeout_o   (timeout),
        .error_o     (mem_error)
    );

    assign mem_req   = req;
    assign mem_we    = req && held_mem && !ld_bit_q;
    assign mem_addr  = alu_q;
    assign mem_wdata = sd_q;

    assign rn_memory          = rn_q;
    assign rd_memory          = rd_q;
    assign opcode_memory      = opcode_q;
    assign sel_w_addr1_memory = sel_q;

    assign wb_valid = alu_vld_q || (state == ST_DONE);
    assign wb_data  = (state != ST_DONE) ? alu_q :
                      timeout            ? 32'h0 :
                      held_load          ? rdata : alu_q;

endmodule
